// File: rtl/instruction_pkg.sv
// Shared definitions for the RV32I instruction encoder: format tags, opcodes,
// immediate range limits and the request payload.
package instruction_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
  localparam int IMM_J_MIN  = -1048576;
  localparam int IMM_J_MAX  = 1048574;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } req_t;

endpackage

// File: rtl/imm_field_packer.sv
// Combinational RV32I field packer: scatters immediate bits per format and
// flags immediates the format cannot represent.
module imm_field_packer
  import instruction_pkg::*;
(
  input  req_t            req,
  output logic [XLEN-1:0] instr,
  output logic            err
);

  logic signed [XLEN-1:0] simm;

  always_comb begin
    simm  = $signed(req.imm);
    instr = '0;
    err   = 1'b0;
    case (req.fmt)
      FMT_R: instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      FMT_I: begin
        instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        err   = (simm < IMM_IS_MIN) || (simm > IMM_IS_MAX);
      end
      FMT_S: begin
        instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        err   = (simm < IMM_IS_MIN) || (simm > IMM_IS_MAX);
      end
      FMT_B: begin
        instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                 req.imm[4:1], req.imm[11], req.opcode};
        err   = (simm < IMM_B_MIN) || (simm > IMM_B_MAX) || req.imm[0];
      end
      FMT_U: begin
        instr = {req.imm[31:12], req.rd, req.opcode};
        err   = |req.imm[11:0];
      end
      FMT_J: begin
        instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
        err   = (simm < IMM_J_MIN) || (simm > IMM_J_MAX) || req.imm[0];
      end
      // Illegal format tags emit a zero word flagged as an error.
      default: begin
        instr = '0;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage pipelined RV32I instruction encoder with valid/ready streams and a
// saturating count of erroneous words delivered.
module instruction_encoder
  import instruction_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_fmt,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic                     out_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  req_t            in_req;
  req_t            s1_req;
  logic            s1_valid;
  logic            s2_free;
  logic [XLEN-1:0] pk_instr;
  logic            pk_err;

  assign in_req = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  // S2 can take a new word when empty or when its current word drains this cycle.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;

  imm_field_packer u_packer (
    .req   (s1_req),
    .instr (pk_instr),
    .err   (pk_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_req   <= in_req;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= pk_instr;
        out_err   <= pk_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized self-checking bench for instruction_encoder with an arithmetic
// reference encoder, a standard immediate decoder and an in-order scoreboard.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  instruction_encoder #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_s;

  typedef struct {
    logic [31:0] instr;
    bit          err;
    req_s        rq;
    int          acc_cyc;
  } exp_s;

  exp_s        scb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          err_model = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  bit          chk_lat = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;
  logic [31:0] last_instr = '0;
  logic        last_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference encoder built from bit positions with shifts and masks.
  function automatic void ref_encode(input req_s r, output logic [31:0] w, output bit e);
    int v;
    v = $signed(r.imm);
    w = '0;
    e = 1'b0;
    case (r.fmt)
      3'd0: w = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
                (32'(r.f3) << 12) | (32'(r.rd) << 7) | 32'(r.op);
      3'd1: begin
        w = ((r.imm & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) |
            (32'(r.rd) << 7) | 32'(r.op);
        e = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w = (((r.imm >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
            (32'(r.f3) << 12) | ((r.imm & 32'h1F) << 7) | 32'(r.op);
        e = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        w = (((r.imm >> 12) & 32'h1) << 31) | (((r.imm >> 5) & 32'h3F) << 25) |
            (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) |
            (((r.imm >> 1) & 32'hF) << 8) | (((r.imm >> 11) & 32'h1) << 7) | 32'(r.op);
        e = (v < -4096) || (v > 4094) || ((v % 2) != 0);
      end
      3'd4: begin
        w = (r.imm & 32'hFFFFF000) | (32'(r.rd) << 7) | 32'(r.op);
        e = (r.imm & 32'hFFF) != 0;
      end
      3'd5: begin
        w = (((r.imm >> 20) & 32'h1) << 31) | (((r.imm >> 1) & 32'h3FF) << 21) |
            (((r.imm >> 11) & 32'h1) << 20) | (((r.imm >> 12) & 32'hFF) << 12) |
            (32'(r.rd) << 7) | 32'(r.op);
        e = (v < -1048576) || (v > 1048574) || ((v % 2) != 0);
      end
      default: begin
        w = '0;
        e = 1'b1;
      end
    endcase
  endfunction

  // Decode-stage immediate extraction, used to close the round trip.
  function automatic logic [31:0] decode_imm(input logic [31:0] w, input logic [2:0] fmt);
    logic [31:0] r;
    case (fmt)
      3'd1:    r = {{20{w[31]}}, w[31:20]};
      3'd2:    r = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    r = {w[31:12], 12'b0};
      default: r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
    return r;
  endfunction

  function automatic req_s mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [31:0] imm);
    req_s r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3;
    r.f7 = 7'($urandom); r.imm = imm;
    return r;
  endfunction

  function automatic req_s rand_req(input bit legal_only);
    req_s r;
    int   bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                      1048574, 1048576, -1048576, -1048578};
    r = mk(3'($urandom_range(0, 5)), 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom), 32'h0);
    case (r.fmt)
      3'd1, 3'd2: r.imm = 32'($signed($urandom_range(0, 4095)) - 2048);
      3'd3:       r.imm = 32'(($signed($urandom_range(0, 4095)) - 2048) * 2);
      3'd4:       r.imm = $urandom & 32'hFFFFF000;
      default:    r.imm = 32'(($signed($urandom_range(0, 1048575)) - 524288) * 2);
    endcase
    if (!legal_only) begin
      r.fmt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       r.imm = $urandom;
        1:       r.imm = 32'(bnd[$urandom_range(0, 11)]);
        default: ;
      endcase
    end
    return r;
  endfunction

  // One clock: drive, sample 1 time unit after the falling edge, update model.
  task automatic step(input bit have_req, input req_s rq, output bit accepted);
    exp_s e;
    @(negedge clk);
    cyc++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    in_valid = have_req;
    in_fmt = rq.fmt; in_opcode = rq.op; in_rd = rq.rd; in_rs1 = rq.rs1; in_rs2 = rq.rs2;
    in_funct3 = rq.f3; in_funct7 = rq.f7; in_imm = rq.imm;
    #1;
    check_eq("err_count", 32'(err_count), 32'(err_model));
    check_eq("in_ready", 32'(in_ready), 32'((scb.size() < 2) || out_ready));
    if (prev_stall) begin
      check_eq("stall_instr", out_instr, prev_instr);
      check_eq("stall_err", 32'(out_err), 32'(prev_err));
    end
    if (out_valid && out_ready) begin
      if (scb.size() == 0) begin
        check_eq("spurious_valid", 32'(out_valid), 32'(0));
      end else begin
        e = scb.pop_front();
        check_eq("instr", out_instr, e.instr);
        check_eq("err", 32'(out_err), 32'(e.err));
        if (chk_lat) check_eq("latency", 32'(cyc - e.acc_cyc), 32'(2));
        if (!e.err && (e.rq.fmt inside {[3'd1:3'd5]}))
          check_eq("roundtrip", decode_imm(out_instr, e.rq.fmt), e.rq.imm);
        if (e.err && err_model < 65535) err_model++;
        last_instr = out_instr;
        last_err   = out_err;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_instr = out_instr;
    prev_err   = out_err;
    accepted = have_req && in_ready;
    if (accepted) begin
      e.rq = rq;
      e.acc_cyc = cyc;
      ref_encode(rq, e.instr, e.err);
      scb.push_back(e);
    end
  endtask

  task automatic send(input req_s rq);
    bit acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) step(1'b1, rq, acc);
    if (!acc) check_eq("accept_timeout", 32'(in_ready), 32'(1));
  endtask

  task automatic drain();
    bit   acc;
    req_s nil;
    nil = mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    for (int i = 0; i < 200 && scb.size() > 0; i++) step(1'b0, nil, acc);
    step(1'b0, nil, acc);
    check_eq("drain_timeout", 32'(scb.size()), 32'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check_eq({tag, "_out_instr"}, out_instr, 32'(0));
    check_eq({tag, "_out_err"}, 32'(out_err), 32'(0));
    check_eq({tag, "_err_count"}, 32'(err_count), 32'(0));
  endtask

  initial begin
    bit acc;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    check_reset_state("reset");
    check_eq("reset_in_ready", 32'(in_ready), 32'(1));

    chk_lat = 1'b1;
    rdy_mode = 0;
    send(mk(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF));
    drain();
    check_eq("addi_word", last_instr, 32'hFFF30293);
    check_eq("addi_err", 32'(last_err), 32'(0));

    send(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_F000));
    send(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096));
    send(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd7));
    drain();
    check_eq("b_err_count", 32'(err_count), 32'(2));

    send(mk(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h12345000));
    drain();
    check_eq("lui_word", last_instr, 32'h123450B7);
    check_eq("lui_err", 32'(last_err), 32'(0));
    send(mk(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h12345001));
    drain();
    check_eq("lui_bad_err", 32'(last_err), 32'(1));

    for (int i = 0; i < 1000; i++) send(rand_req(1'b1));
    drain();

    chk_lat = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(rand_req(1'b1));
    drain();
    for (int i = 0; i < 300; i++) send(rand_req(1'b0));
    drain();

    // Fill both stages, confirm backpressure, then reset mid-stream.
    rdy_mode = 2;
    send(rand_req(1'b0));
    send(rand_req(1'b0));
    step(1'b1, rand_req(1'b0), acc);
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_reset_state("midreset");
    scb.delete();
    err_model  = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    rdy_mode = 0;
    chk_lat = 1'b1;
    send(mk(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 32'hFFFF_F800));
    drain();
    send(mk(3'd7, 7'h13, 5'd5, 5'd6, 5'd7, 3'd0, 32'd0));
    drain();
    check_eq("illegal_word", last_instr, 32'(0));
    check_eq("illegal_err", 32'(last_err), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Pipelined RV32I instruction encoder: packs a format tag, register/function fields and a 32-bit signed immediate into a 32-bit instruction word, the inverse of the immediate extraction done in the decode stage. Sits in the program-loader / self-test path, feeding encoded words to instruction memory over a valid/ready stream. Flags immediates that the selected format cannot represent and keeps a saturating error count.

## Interface
- DATA_WIDTH, 32, instruction and immediate width (only 32 supported)
- ERR_CNT_WIDTH, 16, width of error counter
- clk  input  1  clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept request
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal
- in_opcode  input  7  placed verbatim in [6:0]
- in_rd / in_rs1 / in_rs2  input  5 each  register fields
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7 field (R only)
- in_imm  input  DATA_WIDTH  signed immediate (U: full value, low 12 bits expected zero)
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts word
- out_instr  output  DATA_WIDTH  encoded instruction
- out_err  output  1  immediate out of range or illegal fmt
- err_count  output  ERR_CNT_WIDTH  saturating count of erroneous words delivered

## Operation
- Two register stages: S1 captures request; S2 holds encoded word, out_err.
- Field placement: R {funct7,rs2,rs1,funct3,rd,op}; I {imm[11:0],rs1,funct3,rd,op}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Range rules (err=1 if violated): I,S: -2048..2047; B: -4096..4094, imm[0]=0; J: -1048576..1048574, imm[0]=0; U: imm[11:0]=0; R: immediate ignored, never err.
- On error the word is still packed from the truncated bits; out_err=1.
- Illegal fmt: out_instr=0, out_err=1.
- err_count increments on each out_valid&&out_ready&&out_err; saturates at all-ones.

## Timing
- Reset: S1/S2 empty, out_valid=0, out_instr=0, out_err=0, err_count=0, in_ready=1 after reset deasserts.
- Input handshake at edge when in_valid&&in_ready; output handshake when out_valid&&out_ready.
- Latency: request accepted at edge N appears on out_* after edge N+1 (valid in cycle N+2 window).
- Throughput 1 word/cycle with out_ready held high.
- S2 loads when empty or draining this cycle; S1 advances into S2 under same condition.
- in_ready = !S1_valid || S2 loads this cycle (no combinational path from in_valid).
- Backpressure: out_instr/out_err stable while out_valid&&!out_ready; both stages full -> in_ready=0; no loss, no duplication.
- Simultaneous accept and drain at full pipeline: both occur, occupancy unchanged.
- Reset mid-stream: in-flight words discarded, all outputs to reset values immediately.

## Structure
- Shared package instruction_pkg: fmt encoding localparams (FMT_R..FMT_J), RV32I opcode constants, immediate range limits.
- One combinational sub-module imm_field_packer (fmt, fields, imm -> instr, err); top holds the two stages, handshake and counter.

## Test plan
- I-type addi x5,x6,-1 (op 0x13, f3 0) -> out_instr 0xFFF30293, out_err 0, 2-cycle latency.
- B-type imm=-4096 / imm=4096 / imm=6 odd check (imm=7) -> first legal, second and third out_err=1; err_count=2 after delivery.
- U-type lui imm 0x12345000, rd=1 -> 0x123450B7; imm 0x12345001 -> out_err=1.
- Round trip: 1000 random legal I/S/B/U/J requests; decode with the existing immediate extraction -> returned imm equals in_imm.
- Backpressure: stream 8 requests, out_ready toggled 1-0-0-1 random -> in_ready drops when full, 8 words in order, outputs stable while stalled.
- Reset asserted with both stages full -> out_valid=0, err_count=0 asynchronously; next accepted request delivered normally; illegal fmt 7 -> out_instr 0, out_err 1.
